// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: word-aligned Memory accesses, sub-word load extraction,
// read-modify-write for byte/half stores, and misaligned-access trapping.
module load_store_unit #(
    parameter bit BIG_ENDIAN    = 1'b1,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  SizeM,
    input  logic        UnsignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWD,
    output logic        MemWE,
    output logic        MemRE,
    input  logic [31:0] MemRD,
    output logic [31:0] LoadData,
    output logic        LoadValid,
    output logic        StallM,
    output logic        MisalignM
);

    typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_MERGE, RMW_WRITE} state_t;

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t      state, state_next;
    logic [31:0] cap_addr, cap_data, merged;
    logic [1:0]  cap_size;
    logic        cap_unsigned;

    logic        is_store, is_load, req_word, misaligned, trap;
    logic        accept_load, accept_sub_store, accept_word_store;
    logic [4:0]  cap_shift;
    logic [31:0] rd_shifted, lane_mask, load_ext, merged_next;

    // Bit position of the addressed lane inside the 32-bit word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lo);
        if (size == SZ_BYTE)
            return BIG_ENDIAN ? {~lo, 3'b000} : {lo, 3'b000};
        else if (size == SZ_HALF)
            return BIG_ENDIAN ? {~lo[1], 4'b0000} : {lo[1], 4'b0000};
        else
            return 5'd0;
    endfunction

    // Store wins when both strobes are raised.
    assign is_store   = MemWriteM;
    assign is_load    = MemReadM & ~MemWriteM;
    assign req_word   = (SizeM != SZ_HALF) && (SizeM != SZ_BYTE);
    assign misaligned = (req_word && (ALUOutM[1:0] != 2'b00)) || ((SizeM == SZ_HALF) && ALUOutM[0]);
    assign trap       = MISALIGN_TRAP && misaligned && (is_store || is_load);

    assign accept_load       = (state == IDLE) && is_load && !trap;
    assign accept_sub_store  = (state == IDLE) && is_store && !req_word && !trap;
    assign accept_word_store = (state == IDLE) && is_store && req_word && !trap;

    assign cap_shift  = lane_shift(cap_size, cap_addr[1:0]);
    assign rd_shifted = MemRD >> cap_shift;
    assign lane_mask  = (cap_size == SZ_BYTE) ? 32'h0000_00FF :
                        (cap_size == SZ_HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    always_comb begin
        case (cap_size)
            SZ_BYTE: load_ext = cap_unsigned ? {24'd0, rd_shifted[7:0]}
                                             : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            SZ_HALF: load_ext = cap_unsigned ? {16'd0, rd_shifted[15:0]}
                                             : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_ext = MemRD;
        endcase
    end

    assign merged_next = (MemRD & ~(lane_mask << cap_shift)) | ((cap_data & lane_mask) << cap_shift);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_load)           state_next = LD_WAIT;
                else if (accept_sub_store) state_next = RMW_MERGE;
            end
            LD_WAIT:   state_next = IDLE;
            RMW_MERGE: state_next = RMW_WRITE;
            RMW_WRITE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        MemAddr = {cap_addr[31:2], 2'b00};
        MemWD   = merged;
        MemWE   = 1'b0;
        MemRE   = 1'b0;
        StallM  = 1'b0;
        case (state)
            IDLE: begin
                MemAddr = {ALUOutM[31:2], 2'b00};
                MemWD   = WriteDataM;
                MemWE   = accept_word_store;
                MemRE   = accept_load || accept_sub_store;
                StallM  = accept_load || accept_sub_store;
            end
            RMW_MERGE: StallM = 1'b1;
            RMW_WRITE: MemWE  = 1'b1;
            default: ;
        endcase
        // While reset is asserted nothing may reach Memory or hold the pipeline.
        if (RST) begin
            MemWE  = 1'b0;
            MemRE  = 1'b0;
            StallM = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cap_addr     <= '0;
            cap_data     <= '0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            merged       <= '0;
            LoadData     <= '0;
            LoadValid    <= 1'b0;
            MisalignM    <= 1'b0;
        end else begin
            if (accept_load || accept_sub_store) begin
                cap_addr     <= ALUOutM;
                cap_data     <= WriteDataM;
                cap_size     <= SizeM;
                cap_unsigned <= UnsignedM;
            end
            if (state == RMW_MERGE) merged <= merged_next;
            if (state == LD_WAIT)   LoadData <= load_ext;
            LoadValid <= (state == LD_WAIT);
            MisalignM <= (state == IDLE) && trap;
        end
    end

endmodule
